// File: rtl/uart_tx_serializer_param.sv
`default_nettype none
// =============================================================================
// uart_tx_serializer_param
// Parallel-to-serial UART TX shifter with selectable bit order and load-time parity.
// Revision: 1.0
// =============================================================================
module uart_tx_serializer_param #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] In_Data,
  input  logic                  Data_Valid,
  input  logic                  Busy_In,
  input  logic                  Par_Type,
  input  logic                  ser_en,
  output logic                  Out_Data,
  output logic                  ser_done,
  output logic                  ser_active,
  output logic                  Par_Bit
);

  localparam int                 C_CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(DATA_WIDTH);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  logic [DATA_WIDTH-1:0] r_sreg;
  logic [C_CNT_W-1:0]    r_cnt;
  logic                  r_done;
  logic                  r_active;
  logic                  r_par;

  logic                  w_load;
  logic                  w_shift;
  logic [DATA_WIDTH-1:0] w_sreg_shifted;

  // A load always pre-empts a shift requested in the same cycle.
  assign w_load  = Data_Valid & ~Busy_In;
  assign w_shift = ~w_load & ser_en & (r_cnt != '0);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sreg_shifted = {r_sreg[DATA_WIDTH-2:0], 1'b0};
      assign Out_Data       = r_sreg[DATA_WIDTH-1];
    end else begin : g_lsb_first
      assign w_sreg_shifted = {1'b0, r_sreg[DATA_WIDTH-1:1]};
      assign Out_Data       = r_sreg[0];
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sreg   <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_active <= 1'b0;
      r_par    <= 1'b0;
    end else if (w_load) begin
      r_sreg   <= In_Data;
      r_cnt    <= C_CNT_LOAD;
      r_done   <= 1'b0;
      r_active <= 1'b1;
      r_par    <= Par_Type ? ~^In_Data : ^In_Data;
    end else if (w_shift) begin
      r_sreg <= w_sreg_shifted;
      r_cnt  <= r_cnt - C_CNT_ONE;
      if (r_cnt == C_CNT_ONE) begin
        r_done   <= 1'b1;
        r_active <= 1'b0;
      end else begin
        r_done <= 1'b0;
      end
    end
  end

  assign ser_done   = r_done;
  assign ser_active = r_active;
  assign Par_Bit    = r_par;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer_param.sv
`default_nettype none
// =============================================================================
// tb_uart_tx_serializer_param
// Scoreboard bench for three serializer instances (W=8 LSB, W=8 MSB, W=5 LSB).
// Revision: 1.0
// =============================================================================
module tb_uart_tx_serializer_param;

  logic       CLK;
  logic       RST;
  logic [7:0] In8;
  logic       dv8, dvm, dv5;
  logic       Busy_In, Par_Type, ser_en;
  logic       o8, done8, act8, par8;
  logic       om, donem, actm, parm;
  logic       o5, done5, act5, par5;

  int n_chk  = 0;
  int n_fail = 0;
  bit q8[$];
  bit qm[$];
  bit q5[$];

  uart_tx_serializer_param #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_d8 (
    .CLK(CLK), .RST(RST), .In_Data(In8), .Data_Valid(dv8), .Busy_In(Busy_In),
    .Par_Type(Par_Type), .ser_en(ser_en), .Out_Data(o8), .ser_done(done8),
    .ser_active(act8), .Par_Bit(par8));

  uart_tx_serializer_param #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_m8 (
    .CLK(CLK), .RST(RST), .In_Data(In8), .Data_Valid(dvm), .Busy_In(Busy_In),
    .Par_Type(Par_Type), .ser_en(ser_en), .Out_Data(om), .ser_done(donem),
    .ser_active(actm), .Par_Bit(parm));

  uart_tx_serializer_param #(.DATA_WIDTH(5), .MSB_FIRST(1'b0)) u_d5 (
    .CLK(CLK), .RST(RST), .In_Data(In8[4:0]), .Data_Valid(dv5), .Busy_In(Busy_In),
    .Par_Type(Par_Type), .ser_en(ser_en), .Out_Data(o5), .ser_done(done5),
    .ser_active(act5), .Par_Bit(par5));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, a, e);
    end
  endtask

  task automatic pop_chk(input string nm, inout bit q[$], input logic act);
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: shift with no expected bit queued, actual=%0b expected=none", nm, act);
    end else begin
      chk(nm, {31'd0, act}, {31'd0, q.pop_front()});
    end
  endtask

  // A bit is consumed whenever a shift will be accepted at the next edge.
  always @(negedge CLK) begin
    if (!RST && ser_en && act8 && !(dv8 && !Busy_In)) pop_chk("d8_bit", q8, o8);
    if (!RST && ser_en && actm && !(dvm && !Busy_In)) pop_chk("m8_bit", qm, om);
    if (!RST && ser_en && act5 && !(dv5 && !Busy_In)) pop_chk("d5_bit", q5, o5);
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n);
    ser_en = 1'b1;
    repeat (n) cyc();
  endtask

  // seq lists the transmit order starting at bit n-1.
  task automatic load(input int sel, input logic [7:0] d, input logic pt,
                      input logic [7:0] seq, input int n);
    In8      = d;
    Par_Type = pt;
    case (sel)
      0: begin dv8 = 1'b1; q8.delete(); for (int i = n - 1; i >= 0; i--) q8.push_back(seq[i]); end
      1: begin dvm = 1'b1; qm.delete(); for (int i = n - 1; i >= 0; i--) qm.push_back(seq[i]); end
      default: begin dv5 = 1'b1; q5.delete(); for (int i = n - 1; i >= 0; i--) q5.push_back(seq[i]); end
    endcase
    cyc();
    dv8 = 1'b0;
    dvm = 1'b0;
    dv5 = 1'b0;
  endtask

  initial begin
    RST = 1'b1; In8 = '0; dv8 = 0; dvm = 0; dv5 = 0;
    Busy_In = 0; Par_Type = 0; ser_en = 0;
    repeat (2) cyc();
    chk("rst_out", o8, 0);     chk("rst_done", done8, 0);
    chk("rst_active", act8, 0); chk("rst_par", par8, 0);
    RST = 1'b0;
    run(3);
    chk("idle_done", done8, 0); chk("idle_active", act8, 0); chk("idle_out", o8, 0);

    // W=8 LSB-first, 0xA5 even parity
    load(0, 8'hA5, 1'b0, 8'b1010_0101, 8);
    chk("a5_par", par8, 0); chk("a5_active", act8, 1); chk("a5_first", o8, 1);
    run(7);
    chk("a5_done_early", done8, 0); chk("a5_active_7", act8, 1);
    run(1);
    chk("a5_done", done8, 1); chk("a5_active_end", act8, 0); chk("a5_out_end", o8, 0);
    run(5);
    chk("a5_done_sticky", done8, 1); chk("a5_out_idle", o8, 0);

    // W=8 MSB-first, odd parity
    load(1, 8'hA5, 1'b1, 8'b1010_0101, 8);
    chk("m_a5_par", parm, 1); chk("m_a5_first", om, 1);
    run(8);
    chk("m_a5_done", donem, 1); chk("m_a5_active", actm, 0);
    load(1, 8'h01, 1'b1, 8'b0000_0001, 8);
    chk("m_01_par", parm, 0); chk("m_01_first", om, 0); chk("m_01_done_clr", donem, 0);
    run(8);
    chk("m_01_done", donem, 1);

    // Stall then abort
    load(0, 8'h3C, 1'b0, 8'b0011_1100, 8);
    run(1);
    ser_en = 1'b0;
    cyc(); chk("stall_hold1", o8, 0);
    cyc(); chk("stall_hold2", o8, 0);
    run(2);
    load(0, 8'hFF, 1'b0, 8'hFF, 8);
    chk("abort_out", o8, 1); chk("abort_active", act8, 1); chk("abort_done", done8, 0);
    run(7);
    chk("ff_done_early", done8, 0);
    run(1);
    chk("ff_done", done8, 1); chk("ff_par", par8, 0);

    // Busy gating
    ser_en = 1'b0; Busy_In = 1'b1; dv8 = 1'b1; In8 = 8'h55; Par_Type = 1'b1;
    cyc(); cyc();
    chk("busy_out", o8, 0); chk("busy_done", done8, 1);
    chk("busy_active", act8, 0); chk("busy_par", par8, 0);
    dv8 = 1'b0; Busy_In = 1'b0; ser_en = 1'b1;
    load(0, 8'h55, 1'b1, 8'b1010_1010, 8);
    chk("unbusy_par", par8, 1); chk("unbusy_out", o8, 1); chk("unbusy_active", act8, 1);
    run(8);
    chk("unbusy_done", done8, 1);

    // W=5 instance
    load(2, 8'h13, 1'b0, 8'b0001_1001, 5);
    chk("w5_par", par5, 1); chk("w5_first", o5, 1);
    run(4);
    chk("w5_done_early", done5, 0); chk("w5_active", act5, 1);
    run(1);
    chk("w5_done", done5, 1); chk("w5_active_end", act5, 0); chk("w5_out_end", o5, 0);

    // Asynchronous reset mid-word
    load(0, 8'hA5, 1'b1, 8'b1010_0101, 8);
    run(2);
    #2;
    RST = 1'b1;
    q8.delete();
    #1;
    chk("arst_out", o8, 0); chk("arst_par", par8, 0);
    chk("arst_active", act8, 0); chk("arst_done", done8, 0);
    chk("arst_m_done", donem, 0);
    cyc(); cyc();
    RST = 1'b0;
    run(3);
    chk("post_rst_done", done8, 0); chk("post_rst_active", act8, 0); chk("post_rst_out", o8, 0);

    chk("q8_empty", q8.size(), 0);
    chk("qm_empty", qm.size(), 0);
    chk("q5_empty", q5.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer_param.md
# uart_tx_serializer_param

Parametrised parallel-to-serial shifter for the UART transmit path. It loads a DATA_WIDTH-bit word on a qualified Data_Valid and presents one bit per ser_en cycle on Out_Data. It supports selectable bit order and computes the frame parity bit at load time. It sits between the TX input register and the TX framing FSM/output mux; the FSM drives ser_en and consumes ser_done and Par_Bit.

## Interface
- DATA_WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 0: 0 shifts LSB first (UART standard), 1 shifts MSB first.
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- In_Data  input  DATA_WIDTH  parallel word to serialize.
- Data_Valid  input  1  load request; sampled every cycle.
- Busy_In  input  1  high while the TX FSM is transmitting a frame; blocks loads.
- Par_Type  input  1  0 = even parity, 1 = odd parity; sampled only at load.
- ser_en  input  1  shift enable from the TX FSM.
- Out_Data  output  1  current serial bit; combinational from the shift register.
- ser_done  output  1  level; high after the final shift until the next load.
- ser_active  output  1  high from load until the final shift.
- Par_Bit  output  1  registered parity of the loaded word.

## Operation
- Internal state: shift register sreg[DATA_WIDTH-1:0] and a down-counter cnt of width $clog2(DATA_WIDTH+1).
- Reset (RST=1, asynchronous): sreg=0, cnt=0, ser_done=0, ser_active=0, Par_Bit=0. Out_Data therefore reads 0.
- Priority per cycle is load, then shift, then hold.
- Load, when Data_Valid && !Busy_In:
  - sreg <= In_Data, cnt <= DATA_WIDTH, ser_done <= 0, ser_active <= 1.
  - Par_Bit <= ^In_Data when Par_Type=0; ~^In_Data when Par_Type=1.
  - A load while ser_active=1 aborts the current word and restarts with the new one.
  - Load wins over a simultaneous ser_en; that ser_en is ignored.
- Shift, when not loading and ser_en && cnt != 0:
  - LSB-first: sreg <= {1'b0, sreg[W-1:1]}. MSB-first: sreg <= {sreg[W-2:0], 1'b0}.
  - cnt <= cnt-1.
  - If cnt==1: ser_done <= 1 and ser_active <= 0. Otherwise ser_done <= 0.
- Hold: when ser_en && cnt==0, or when ser_en=0, all state is unchanged. ser_done stays sticky-high after completion.
- Data_Valid while Busy_In=1 is dropped, with no state change.
- Par_Bit is stable from the cycle after load until the next load; it is not affected by shifts.
- Out_Data = MSB_FIRST ? sreg[W-1] : sreg[0].

## Timing
- Load latency is 1 cycle: the first bit (bit0, or bit W-1 when MSB_FIRST=1) is on Out_Data in the cycle after the load edge.
- Bit k of the transmit order is on Out_Data while cnt == W-k, i.e. after k accepted shifts.
- ser_en gaps stall the sequence; Out_Data holds its bit for as many cycles as ser_en stays low.
- ser_done and ser_active change on the same edge as the W-th accepted shift. On that edge Out_Data becomes 0.
- Minimum word time is W+1 cycles: 1 load cycle plus W shift cycles. Back-to-back loads are allowed on any cycle with Busy_In=0.
- Asserting RST mid-word clears everything immediately, without waiting for a clock edge. The first load is accepted on the first clock edge after RST is released.

## Test plan
- Reset: assert RST mid-shift with no clock edge -> all outputs 0 immediately; after release, ser_en pulses leave cnt=0 and ser_done=0.
- W=8, LSB-first, load 0xA5, Par_Type=0, continuous ser_en -> Out_Data 1,0,1,0,0,1,0,1; Par_Bit=0; ser_done rises on the 8th shift edge and stays high through 5 further ser_en cycles.
- W=8, MSB_FIRST=1, load 0xA5, Par_Type=1 -> Out_Data 1,0,1,0,0,1,0,1 (MSB order); Par_Bit=1. Then load 0x01 with Par_Type=1 -> Par_Bit=0.
- Stall and abort: ser_en pattern 1,0,0,1 with 0x3C holds each bit across the gaps. A new load of 0xFF after 3 shifts, issued with ser_en=1 in the same cycle, restarts cnt at 8 and Out_Data=1.
- Busy gating: Data_Valid with Busy_In=1 and In_Data=0x55 -> no change to sreg, cnt or flags; the same request with Busy_In=0 loads.
- W=5 instance, load 5'b10011, LSB-first -> Out_Data 1,1,0,0,1; ser_done after exactly 5 shifts; Par_Bit=1 (even parity).
